// File: rtl/pool2d_stream.sv
// 2x2 / 2x1 max or average pooling over a column stream; 1-cycle latency from the completing beat.
// Single output register: input stalls only while that register is full and out_ready is low.
module pool2d_stream #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 24,
  parameter int COL_W  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [COL_W-1:0]             col,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_W-1:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(ROWS/2)*DATA_W-1:0]   out_data,
  output logic                         out_last
);

  localparam int K  = ROWS / 2;
  localparam int EW = DATA_W + 2;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state_q;
  logic [1:0]               mode_q;
  logic [COL_W-1:0]         col_q;
  logic [COL_W-1:0]         col_cnt;
  logic [K-1:0][EW-1:0]     hold_q;

  logic [1:0]               eff_mode;
  logic [COL_W-1:0]         eff_col;
  logic                     is_avg, is_vert, last, produce, accept;
  logic [K-1:0][EW-1:0]     v, pair, avg4, lone, r;
  logic [K*DATA_W-1:0]      out_nxt;

  // Elements are widened by two bits so every intermediate can use signed ops;
  // zero-extension keeps unsigned values non-negative under signed compare/shift.
  function automatic logic [EW-1:0] ext(input logic [DATA_W-1:0] x);
    if (SIGNED) ext = {{2{x[DATA_W-1]}}, x};
    else        ext = {2'b00, x};
  endfunction

  function automatic logic [EW-1:0] smax(input logic [EW-1:0] a, input logic [EW-1:0] b);
    smax = ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    eff_mode = (col_cnt == '0) ? mode : mode_q;
    eff_col  = (col_cnt == '0) ? ((col == '0) ? COL_W'(1) : col) : col_q;
    last     = (col_cnt == eff_col - COL_W'(1));
    is_avg   = (eff_mode == 2'b01);
    is_vert  = (eff_mode == 2'b10);
    produce  = is_vert || (state_q == HOLD) || last;
    v        = '0;
    pair     = '0;
    avg4     = '0;
    lone     = '0;
    r        = '0;
    out_nxt  = '0;
    for (int k = 0; k < K; k++) begin
      v[k] = is_avg ? ext(in_data[2*k*DATA_W +: DATA_W]) + ext(in_data[(2*k+1)*DATA_W +: DATA_W])
                    : smax(ext(in_data[2*k*DATA_W +: DATA_W]), ext(in_data[(2*k+1)*DATA_W +: DATA_W]));
      pair[k] = hold_q[k] + v[k] + EW'(2);
      avg4[k] = $signed(pair[k]) >>> 2;
      lone[k] = $signed(v[k] + EW'(1)) >>> 1;
      if (is_vert)               r[k] = v[k];
      else if (state_q == HOLD)  r[k] = is_avg ? avg4[k] : smax(hold_q[k], v[k]);
      else                       r[k] = is_avg ? lone[k] : v[k];
      out_nxt[k*DATA_W +: DATA_W] = DATA_W'(r[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      col_q     <= '0;
      col_cnt   <= '0;
      hold_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (col_cnt == '0) begin
          mode_q <= mode;
          col_q  <= eff_col;
        end
        col_cnt <= last ? '0 : col_cnt + COL_W'(1);
        if (!is_vert && state_q == IDLE && !last) begin
          hold_q  <= v;
          state_q <= HOLD;
        end else begin
          state_q <= IDLE;
        end
      end
      if (accept && produce) begin
        out_valid <= 1'b1;
        out_data  <= out_nxt;
        out_last  <= last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream (DATA_W=8, ROWS=4, SIGNED=0).
module tb_pool2d_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] col = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [15:0] od_q[$];
  logic        ol_q[$];
  int          oc_q[$];
  int          acc_q[$];

  pool2d_stream #(.DATA_W(8), .ROWS(4), .COL_W(16), .SIGNED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .col(col),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc_n++;
    if (in_valid && in_ready) acc_q.push_back(cyc_n);
    if (out_valid && out_ready) begin
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
      oc_q.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only at posedge+1; returns at posedge+1 so calls chain back-to-back.
  task automatic send(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clr();
    od_q.delete(); ol_q.delete(); oc_q.delete(); acc_q.delete();
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #3;
    chk("rst_vld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_rdy", in_ready, 0);
    #17 rst_n = 1'b1;
    #1 chk("rel_rdy", in_ready, 1);

    // max 2x2, col=4
    mode = 2'b00; col = 16'd4; clr(); sync();
    send(pk(1,5,2,3)); send(pk(4,0,9,9)); send(pk(7,7,7,7)); send(pk(8,1,0,6));
    drain();
    chk("m00_n", od_q.size(), 2);
    chk("m00_d0", od_q[0], 16'h0905); chk("m00_l0", ol_q[0], 0);
    chk("m00_d1", od_q[1], 16'h0708); chk("m00_l1", ol_q[1], 1);
    chk("m00_lat0", oc_q[0], acc_q[1] + 1);
    chk("m00_lat1", oc_q[1], acc_q[3] + 1);

    // avg 2x2, col=3 with lone last column
    mode = 2'b01; col = 16'd3; clr(); sync();
    send(pk(1,2,3,4)); send(pk(5,6,7,8)); send(pk(10,11,0,1));
    drain();
    chk("m01_n", od_q.size(), 2);
    chk("m01_d0", od_q[0], 16'h0604); chk("m01_l0", ol_q[0], 0);
    chk("m01_d1", od_q[1], 16'h010B); chk("m01_l1", ol_q[1], 1);

    // vertical only, col=2
    mode = 2'b10; col = 16'd2; clr(); sync();
    send(pk(3,9,250,255)); send(pk(0,0,1,0));
    drain();
    chk("m10_n", od_q.size(), 2);
    chk("m10_d0", od_q[0], 16'hFF09); chk("m10_l0", ol_q[0], 0);
    chk("m10_d1", od_q[1], 16'h0100); chk("m10_l1", ol_q[1], 1);
    chk("m10_lat0", oc_q[0], acc_q[0] + 1);
    chk("m10_b2b", oc_q[1], oc_q[0] + 1);

    // backpressure with a beat waiting
    mode = 2'b00; col = 16'd2; out_ready = 1'b0; clr(); sync();
    send(pk(1,2,3,4)); send(pk(6,5,0,9));
    fork
      begin
        send(pk(9,1,1,1)); send(pk(0,0,2,2));
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_vld", out_valid, 1);
          chk("bp_dat", out_data, 16'h0906);
          chk("bp_last", out_last, 1);
          chk("bp_rdy", in_ready, 0);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_n", od_q.size(), 2);
    chk("bp_d0", od_q[0], 16'h0906); chk("bp_l0", ol_q[0], 1);
    chk("bp_d1", od_q[1], 16'h0209); chk("bp_l1", ol_q[1], 1);
    chk("bp_acc", acc_q.size(), 4);

    // reset mid-frame with an output pending
    mode = 2'b10; col = 16'd4; out_ready = 1'b0; clr(); sync();
    send(pk(1,5,2,3));
    @(negedge clk);
    chk("prerst_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_dat", out_data, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; mode = 2'b00; col = 16'd4; clr(); sync();
    send(pk(4,0,9,9)); send(pk(7,7,7,7));
    drain();
    chk("mrst_n", od_q.size(), 1);
    chk("mrst_d0", od_q[0], 16'h0907); chk("mrst_l0", ol_q[0], 0);
    sync();
    send(pk(0,0,0,0)); send(pk(0,0,0,0));
    drain();
    chk("mrst_d1", od_q[1], 16'h0000); chk("mrst_l1", ol_q[1], 1);

    // col/mode changed mid-frame are ignored until the next frame
    mode = 2'b00; col = 16'd4; clr(); sync();
    send(pk(1,2,3,4));
    mode = 2'b01; col = 16'd2;
    send(pk(0,0,0,0)); send(pk(5,5,5,5)); send(pk(6,0,0,6));
    send(pk(4,4,8,8)); send(pk(0,0,0,0));
    drain();
    chk("cc_n", od_q.size(), 3);
    chk("cc_d0", od_q[0], 16'h0402); chk("cc_l0", ol_q[0], 0);
    chk("cc_d1", od_q[1], 16'h0606); chk("cc_l1", ol_q[1], 1);
    chk("cc_d2", od_q[2], 16'h0402); chk("cc_l2", ol_q[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 Parameters: DATA_W, default 8, element width in bits; ROWS, default 24, rows per input column (even, >=2); COL_W, default 16, width of the column-count port; SIGNED, default 0, element compare/sum is signed when 1.
REQ-002 Ports: clk  in  1  clock; rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-003 mode  in  2  00 = max 2x2, 01 = avg 2x2, 10 = max 2x1 (vertical only), 11 = same as 00.
REQ-004 col  in  COL_W  columns per frame.
REQ-005 in_valid  in  1;  in_ready  out  1;  in_data  in  ROWS*DATA_W  one column, row r at bits [r*DATA_W +: DATA_W].
REQ-006 out_valid  out  1;  out_ready  in  1;  out_data  out  (ROWS/2)*DATA_W  pooled column, row k at [k*DATA_W +: DATA_W];  out_last  out  1  final output of frame.

Function
REQ-007 Beat accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
REQ-008 in_ready = !out_valid || out_ready, combinational; no other stall source.
REQ-009 mode and col sampled into internal registers on the first accepted beat of a frame (col_cnt == 0); changes mid-frame ignored.
REQ-010 col sampled as 0 is treated as 1.
REQ-011 col_cnt counts accepted beats 0..col-1, wraps to 0 after beat col-1, which is the frame's last beat.
REQ-012 Vertical reduce per accepted beat: v[k] = f(row 2k, row 2k+1), f = max (modes 00/10) or sum at DATA_W+1 bits (mode 01).
REQ-013 Mode 10: every accepted beat loads output register with v[k], one-cycle latency; out_last set on frame's last beat.
REQ-014 Modes 00/01, even col_cnt and not last beat: v stored in hold register; no output produced.
REQ-015 Modes 00/01, odd col_cnt: output = max(hold[k], v[k]) (00) or (hold[k] + v[k] + 2) >> 2 at DATA_W+2 bits, truncated to DATA_W (01); loaded next edge.
REQ-016 Odd col, last beat at even col_cnt: lone-column output = v[k] (00) or (v[k] + 1) >> 1 (01); out_last = 1.
REQ-017 Rounding: half-up; SIGNED = 1 uses arithmetic shift (floor of sum+bias).
REQ-018 Output register: loads when an output is produced; out_valid, out_data, out_last hold stable until transfer; out_valid clears on transfer with no new load; simultaneous transfer and load keeps out_valid = 1 with new data (full throughput).
REQ-019 Latency: accepted completing beat to out_valid = 1 cycle.
REQ-020 out_last asserts only with out_valid on the final output of a frame; else 0.
REQ-021 Frames back-to-back with no idle cycle; next beat after last starts new frame, re-sampling mode/col.
REQ-022 Pair-completion state: IDLE (col_cnt = 0) -> HOLD (even beat stored) -> IDLE on odd beat or wrap; HOLD persists across in_valid gaps indefinitely.

Reset
REQ-023 rst_n low asynchronously clears col_cnt, hold register, sampled mode/col, out_valid, out_data, out_last to 0; state IDLE.
REQ-024 Reset mid-frame discards partial window; first beat after release starts a new frame.
REQ-025 in_ready is 1 while reset deasserted and output register empty; outputs held at 0 during reset.

Verification (DATA_W=8, ROWS=4, SIGNED=0)
REQ-026 Mode 00, col=4, beats [1,5,2,3],[4,0,9,9],[7,7,7,7],[8,1,0,6], out_ready=1 -> outputs [5,9] then [8,7], second with out_last=1, each 1 cycle after odd beat.
REQ-027 Mode 01, col=3, beats [1,2,3,4],[5,6,7,8],[10,11,0,1] -> [4,6] ((1+2+5+6+2)>>2, (3+4+7+8+2)>>2), then lone [11,1] with out_last=1.
REQ-028 Mode 10, col=2, beats [3,9,250,255],[0,0,1,0] -> [9,255] then [0,1] out_last=1; out_valid each cycle.
REQ-029 Backpressure: out_ready=0 for 5 cycles while output pending -> out_valid/out_data/out_last stable, in_ready=0; after out_ready=1 no beat lost or duplicated.
REQ-030 rst_n pulsed low mid-cycle after first beat of a col=4 frame -> outputs 0 immediately; next 2 beats produce one fresh pooled output with out_last=0.
REQ-031 col changed from 4 to 2 after frame's first beat -> frame still ends after 4 beats; following frame uses 2.
